// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial unsigned subtractor with IDLE/RUN/DONE control
//
// Computes diff = a - b (mod 2^WIDTH) and borrow = (a < b), one bit per clock,
// LSB first, through a single 1-bit slice made of two half-subtractor stages.
//
// Ports:
//   clk    in   1      clock, all state changes on rising edge
//   rst    in   1      synchronous active-high reset, highest priority
//   start  in   1      begin an operation; only looked at in IDLE
//   a      in   WIDTH  minuend, captured when start is accepted
//   b      in   WIDTH  subtrahend, captured when start is accepted
//   busy   out  1      registered, high in RUN and DONE
//   done   out  1      registered one-cycle pulse when diff/borrow are updated
//   diff   out  WIDTH  registered result, held between operations
//   borrow out  1      registered final borrow, held between operations

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             hs1_d;
    logic             hs1_bo;
    logic             hs2_d;
    logic             hs2_bo;
    logic             last_bit;

    // First half-subtractor: a_i - b_i; second: (a_i - b_i) - borrow_in.
    assign hs1_d    = a_sh[0] ^ b_sh[0];
    assign hs1_bo   = ~a_sh[0] & b_sh[0];
    assign hs2_d    = hs1_d ^ br;
    assign hs2_bo   = ~hs1_d & br;

    // Counter holds the index of the bit being processed this cycle.
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            // busy mirrors the state being entered so it is itself a flop.
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {hs2_d, res[WIDTH-1:1]};
                    br   <= hs1_bo | hs2_bo;
                    cnt  <= cnt + CW'(1);
                    // Publish on the edge that processes the MSB, using the
                    // just-computed bit rather than the not-yet-updated res.
                    if (last_bit) begin
                        diff   <= {hs2_d, res[WIDTH-1:1]};
                        borrow <= hs1_bo | hs2_bo;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard testbench for serial_sub_ctrl (WIDTH=8)

module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    int tests;
    int fails;
    int done_cnt;
    int lat;

    logic [8:0] exp_q[$];

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("result", {23'd0, borrow, diff}, {23'd0, e});
            end
        end
    end

    // Drives start for one edge (E0); returns #1 after E0.
    task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv, input bit push);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) exp_q.push_back({(av < bv) ? 1'b1 : 1'b0, 8'(av - bv)});
    endtask

    // Called #1 after E0; counts edges (E0 = 1) until done is seen.
    // With hold set, diff/borrow must keep prev values until then.
    task automatic wait_done(input bit hold, input logic [8:0] prev, output int n);
        n = 1;
        while (!done && n < 40) begin
            if (hold) check("hold", {23'd0, borrow, diff}, {23'd0, prev});
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int d0;
        int seen;
        int t[$];
        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 200 - 55
        pulse_start(8'd200, 8'd55, 1'b1);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(1'b0, 9'd0, lat);
        check("latency", lat, 32'd9);
        check("diff_145", {24'd0, diff}, 32'd145);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);

        // 5 - 9 with diff held at 145 until done
        pulse_start(8'd5, 8'd9, 1'b1);
        wait_done(1'b1, {1'b0, 8'd145}, lat);
        @(posedge clk);
        #1;

        // 0 - FF, full borrow ripple
        pulse_start(8'd0, 8'hFF, 1'b1);
        wait_done(1'b0, 9'd0, lat);
        check("diff_01", {24'd0, diff}, 32'h01);
        @(posedge clk);
        #1;

        // Reset at the 3rd RUN edge aborts the operation
        d0 = done_cnt;
        pulse_start(8'd100, 8'd1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_borrow", {31'd0, borrow}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 32'd0);
        pulse_start(8'd10, 8'd3, 1'b1);
        wait_done(1'b0, 9'd0, lat);
        check("diff_7", {24'd0, diff}, 32'd7);
        @(posedge clk);
        #1;

        // AA - AA, with a start pulse during RUN that must be ignored
        d0 = done_cnt;
        pulse_start(8'hAA, 8'hAA, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        pulse_start(8'd1, 8'd2, 1'b0);
        a = 8'd0;
        b = 8'd0;
        wait_done(1'b0, 9'd0, lat);
        repeat (14) @(posedge clk);
        #1;
        check("ignored_start_one_done", done_cnt - d0, 32'd1);
        check("eq_diff", {23'd0, borrow, diff}, 32'd0);

        // start held for 30 edges: one op every 10 cycles
        a     = 8'd9;
        b     = 8'd4;
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 || k == 10 || k == 20) exp_q.push_back({1'b0, 8'd5});
            if (done) t.push_back(k);
        end
        start = 1'b0;
        seen  = t.size();
        check("held_count", seen, 32'd3);
        if (seen == 3) begin
            check("held_first", t[0], 32'd8);
            check("held_gap1", t[1] - t[0], 32'd10);
            check("held_gap2", t[2] - t[1], 32'd10);
        end
        repeat (15) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; captured on the edge that accepts start.
REQ-007 busy  output  1  high while an operation is in progress (RUN or DONE state).
REQ-008 done  output  1  one-cycle pulse marking diff/borrow updated with a new result.
REQ-009 diff  output  WIDTH  registered result a-b modulo 2^WIDTH.
REQ-010 borrow  output  1  registered final borrow; 1 iff a < b unsigned.
REQ-011 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Function
REQ-012 The block SHALL compute a-b bit-serially, LSB first, one bit per clock, using a single 1-bit subtractor slice built from two half-subtractor stages.
REQ-013 Half-subtractor stage: d = x^y, bo = ~x&y.
REQ-014 Slice per bit i SHALL use: d_i = a_i ^ b_i ^ br, br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE: busy=0, done=0; start=1 at an edge latches a and b into shift registers, clears the internal borrow and the bit counter, and moves to RUN.
REQ-017 RUN: each edge processes one bit, shifts the operands, shifts d_i into the result register MSB-ward and increments the bit counter.
REQ-018 RUN: the edge processing bit WIDTH-1 SHALL move to DONE.
REQ-019 DONE transition: the same edge that enters DONE SHALL load diff and borrow from the internal result and borrow.
REQ-020 DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
REQ-021 Latency: with start accepted at edge E0, bits are processed at E1..E_WIDTH, and done=1 in the cycle following E_WIDTH (WIDTH+1 cycles after E0).
REQ-022 Throughput: at most one operation per WIDTH+2 cycles; start held high continuously SHALL start a new operation at the first edge seen in IDLE.
REQ-023 start in RUN or DONE SHALL be ignored, with no effect on the operation or its operands; there is no queuing.
REQ-024 diff and borrow SHALL hold the previous result, unchanged during RUN, until the next DONE entry.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within an operation.
REQ-026 a == b SHALL yield diff=0, borrow=0.
REQ-027 a < b SHALL yield the two's-complement wrap of the difference and borrow=1.

Reset
REQ-028 rst=1 at an edge SHALL set state=IDLE, busy=0, done=0, diff=0, borrow=0, and clear the internal borrow, counter and shift registers.
REQ-029 rst SHALL take priority over start and over every state transition.
REQ-030 rst asserted mid-RUN SHALL abort the operation: no done pulse, and diff/borrow are cleared.
REQ-031 After rst deasserts, the first start seen in IDLE SHALL be accepted normally.

Verification
REQ-032 WIDTH=8, a=200, b=55, start 1 cycle -> busy=1 from the next cycle; done=1 exactly 9 cycles after the start edge; diff=145, borrow=0.
REQ-033 a=5, b=9 -> diff=8'hFC, borrow=1; diff stays at the prior value (145) until the done cycle.
REQ-034 a=0, b=8'hFF -> borrow ripples through all 8 bits; diff=8'h01, borrow=1.
REQ-035 a=b=8'hAA -> diff=0, borrow=0; then start re-pulsed in RUN with a=1, b=2 -> ignored; result still 0/0 and exactly one done pulse.
REQ-036 Start accepted, rst=1 at the 3rd RUN edge -> next cycle busy=0, diff=0, borrow=0, no done; a new start of 10-3 -> diff=7, borrow=0.
REQ-037 start held high for 30 cycles with a=9, b=4 -> done pulses every 10 cycles, each with diff=5, borrow=0.
